// File: rtl/cpu_types_pkg.sv
// Shared CPU types: address split and frame layout for the default
// 16-set instruction cache.
package cpu_types_pkg;

   localparam int unsigned ISETS  = 16;
   localparam int unsigned IIDX_W = $clog2(ISETS);
   localparam int unsigned ITAG_W = 30 - IIDX_W;

   typedef struct packed {
      logic [ITAG_W-1:0] tag;
      logic [IIDX_W-1:0] idx;
      logic [1:0]        bytoff;
   } icachef_t;

   typedef struct packed {
      logic              valid;
      logic [ITAG_W-1:0] tag;
      logic [31:0]       data;
   } icache_frame_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hits,
// single-word refill from memory on a miss.
module icache
   import cpu_types_pkg::*;
#(
   parameter int unsigned SETS = ISETS
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
);

   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned TAG_W = 30 - IDX_W;

   typedef enum logic {COMPARE, FETCH} state_t;

   state_t            state, next_state;
   logic [SETS-1:0]   valid;
   logic [TAG_W-1:0]  tags [SETS];
   logic [31:0]       data [SETS];
   logic [29:0]       miss_addr;

   logic [TAG_W-1:0]  req_tag, miss_tag;
   logic [IDX_W-1:0]  req_idx, miss_idx;
   logic              fill, latch_miss;
   logic              unused_boff;

   assign req_tag     = imemaddr[31:2+IDX_W];
   assign req_idx     = imemaddr[2+IDX_W-1:2];
   assign miss_tag    = miss_addr[29:IDX_W];
   assign miss_idx    = miss_addr[IDX_W-1:0];
   assign unused_boff = ^imemaddr[1:0];

   always_comb begin
      next_state = state;
      ihit       = 1'b0;
      iREN       = 1'b0;
      iaddr      = '0;
      imemload   = data[req_idx];
      fill       = 1'b0;
      latch_miss = 1'b0;
      case (state)
         COMPARE: begin
            ihit = imemREN && valid[req_idx] && (tags[req_idx] == req_tag);
            if (imemREN && !ihit) begin
               latch_miss = 1'b1;
               next_state = FETCH;
            end
         end
         FETCH: begin
            iREN  = 1'b1;
            iaddr = {miss_addr, 2'b00};
            if (!iwait) begin
               fill       = 1'b1;
               next_state = COMPARE;
            end
         end
         default: next_state = COMPARE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= COMPARE;
         valid     <= '0;
         miss_addr <= '0;
         for (int unsigned i = 0; i < SETS; i++) begin
            tags[i] <= '0;
            data[i] <= '0;
         end
      end else begin
         state <= next_state;
         if (latch_miss)
            miss_addr <= {req_tag, req_idx};
         // fill uses the latched miss address, never the live request
         if (fill) begin
            valid[miss_idx] <= 1'b1;
            tags[miss_idx]  <= miss_tag;
            data[miss_idx]  <= iload;
         end
      end
   end

endmodule

// File: tb/tb_icache.sv
// Randomized and directed bench for icache against a cache-contents
// reference model kept as plain arrays.
module tb_icache;

   localparam int unsigned SETS = 16;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;

   int total = 0;
   int bad   = 0;

   // reference model: which word address each set holds, plus pending miss
   logic        m_valid [SETS];
   logic [29:0] m_word  [SETS];
   logic        m_busy;
   logic [29:0] m_addr;

   icache #(.SETS(SETS)) dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
      .iwait(iwait), .iload(iload)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] memword(input logic [29:0] w);
      logic [31:0] x;
      if (w == 30'h10) return 32'h8C010004;
      x = {2'b00, w} * 32'h9E3779B1;
      return x + 32'h01234567;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < SETS; i++) begin
         m_valid[i] = 1'b0;
         m_word[i]  = '0;
      end
      m_busy = 1'b0;
      m_addr = '0;
   endtask

   // one clock: drive, check combinational outputs, advance model
   task automatic cycle(input logic ren, input logic [31:0] addr, input logic iw);
      logic [29:0] w;
      int          s;
      logic        e_hit;
      @(posedge CLK);
      #1;
      imemREN  = ren;
      imemaddr = addr;
      iwait    = iw;
      iload    = memword(m_addr);
      #1;
      w = addr[31:2];
      s = int'(w % SETS);
      if (!m_busy) begin
         e_hit = ren && m_valid[s] && (m_word[s] == w);
         check("ihit", {31'b0, ihit}, {31'b0, e_hit});
         check("iREN", {31'b0, iREN}, 32'd0);
         check("iaddr", iaddr, 32'd0);
         if (e_hit) check("imemload", imemload, memword(w));
         if (ren && !e_hit) begin
            m_busy = 1'b1;
            m_addr = w;
         end
      end else begin
         check("ihit_fetch", {31'b0, ihit}, 32'd0);
         check("iREN_fetch", {31'b0, iREN}, 32'd1);
         check("iaddr_fetch", iaddr, {m_addr, 2'b00});
         if (!iw) begin
            m_valid[int'(m_addr % SETS)] = 1'b1;
            m_word[int'(m_addr % SETS)]  = m_addr;
            m_busy = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      @(posedge CLK);
      #1;
      nRST    = 1'b0;
      imemREN = 1'b0;
      #1;
      check("rst_iREN", {31'b0, iREN}, 32'd0);
      check("rst_ihit", {31'b0, ihit}, 32'd0);
      check("rst_iaddr", iaddr, 32'd0);
      model_reset();
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   initial begin
      logic [31:0] a;
      nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
      model_reset();
      #12;
      imemREN = 1'b1; imemaddr = 32'h40;
      #1;
      check("reset_ihit", {31'b0, ihit}, 32'd0);
      check("reset_iREN", {31'b0, iREN}, 32'd0);
      check("reset_iaddr", iaddr, 32'd0);
      imemREN = 1'b0;
      @(posedge CLK); #1 nRST = 1'b1;

      // cold miss with two wait cycles, then warm hit and byte offset
      cycle(1, 32'h40, 1);
      cycle(1, 32'h40, 1);
      cycle(1, 32'h40, 1);
      cycle(1, 32'h40, 0);
      cycle(1, 32'h40, 1);
      check("cold_data", imemload, 32'h8C010004);
      cycle(1, 32'h40, 1);
      cycle(1, 32'h43, 1);
      cycle(0, 32'h40, 1);

      // conflict eviction on set 0
      cycle(1, 32'h80, 1);
      cycle(1, 32'h80, 0);
      cycle(1, 32'h80, 1);
      cycle(1, 32'h40, 1);
      cycle(1, 32'h40, 0);
      cycle(1, 32'h40, 1);
      cycle(1, 32'h80, 1);
      cycle(1, 32'h80, 0);
      cycle(1, 32'h80, 1);

      // address change while fetching
      cycle(1, 32'h44, 1);
      cycle(1, 32'h100, 1);
      cycle(1, 32'h100, 1);
      cycle(1, 32'h100, 0);
      cycle(1, 32'h100, 0);
      cycle(1, 32'h100, 0);
      cycle(1, 32'h44, 1);
      check("frame1_hit", {31'b0, ihit}, 32'd1);

      // reset in the middle of a fill, then 0x40 must miss
      cycle(1, 32'h40, 1);
      cycle(1, 32'h40, 1);
      cycle(1, 32'h48, 1);
      do_reset();
      cycle(1, 32'h40, 1);
      check("post_reset_miss", {31'b0, ihit}, 32'd0);
      cycle(1, 32'h40, 0);
      cycle(1, 32'h40, 1);

      // random traffic over a small address pool
      for (int n = 0; n < 3000; n++) begin
         a = {22'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 2'($urandom)};
         cycle(($urandom_range(0, 9) < 8), a, $urandom_range(0, 1) == 1);
         if (n % 997 == 500) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
